// File: rtl/register_bank.sv
// register_bank: multi-port configuration/status register bank.
// Bus writes use byte-lane strobes and per-register RW/RO/W1C modes. A hardware
// update port sets status bits. N_RD independent read ports return data RD_LAT
// cycles after the request, and the live register image is exported on o_mem.
module register_bank #(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 32,
   parameter int               N_RD     = 2,
   parameter int               LANE_W   = 8,
   parameter int               RD_LAT   = 1,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter logic [DEPTH-1:0] RO_MASK  = '0,
   parameter logic [DEPTH-1:0] W1C_MASK = '0,
   localparam int              NL       = (WIDTH + LANE_W - 1) / LANE_W,
   localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_w_en,
   input  logic [AW-1:0]           i_w_addr,
   input  logic [WIDTH-1:0]        i_w_value,
   input  logic [NL-1:0]           i_w_strb,
   output logic                    o_w_err,
   input  logic                    i_hw_en,
   input  logic [AW-1:0]           i_hw_addr,
   input  logic [WIDTH-1:0]        i_hw_value,
   input  logic [N_RD-1:0]         i_r_en,
   input  logic [N_RD*AW-1:0]      i_r_addr,
   output logic [N_RD*WIDTH-1:0]   o_r_value,
   output logic [N_RD-1:0]         o_r_valid,
   output logic [WIDTH-1:0]        o_mem [DEPTH]
);

   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] mem_nxt [DEPTH];
   logic [WIDTH-1:0] w_mask;
   logic             w_reject;
   logic             w_addr_ok;

   // Expand lane strobes to a per-bit mask; the top lane may be partial.
   function automatic logic [WIDTH-1:0] lane_mask(input logic [NL-1:0] strb);
      logic [WIDTH-1:0] m;
      for (int b = 0; b < WIDTH; b++) begin
         m[b] = strb[b / LANE_W];
      end
      return m;
   endfunction

   assign w_mask = lane_mask(i_w_strb);
   assign o_mem  = mem;

   // Next register image: hardware update first, then bus write lanes; for W1C
   // the hardware set is applied last so a set beats a same-cycle clear.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_nxt[i] = mem[i];
         if (RO_MASK[i]) begin
            if (i_hw_en && (i_hw_addr == AW'(i))) begin
               mem_nxt[i] = i_hw_value;
            end
         end else if (W1C_MASK[i]) begin
            if (i_w_en && (i_w_addr == AW'(i))) begin
               mem_nxt[i] = mem_nxt[i] & ~(i_w_value & w_mask);
            end
            if (i_hw_en && (i_hw_addr == AW'(i))) begin
               mem_nxt[i] = mem_nxt[i] | i_hw_value;
            end
         end else begin
            if (i_hw_en && (i_hw_addr == AW'(i))) begin
               mem_nxt[i] = i_hw_value;
            end
            if (i_w_en && (i_w_addr == AW'(i))) begin
               mem_nxt[i] = (mem_nxt[i] & ~w_mask) | (i_w_value & w_mask);
            end
         end
      end
   end

   // Reject a strobed bus write aimed at a read-only or nonexistent register.
   always_comb begin
      w_reject  = 1'b0;
      w_addr_ok = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_w_addr == AW'(i)) begin
            w_addr_ok = 1'b1;
            if (RO_MASK[i]) begin
               w_reject = 1'b1;
            end
         end
      end
      if (!w_addr_ok) begin
         w_reject = 1'b1;
      end
      w_reject = w_reject && i_w_en && (i_w_strb != '0);
   end

   // Register array update.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            mem[i] <= RST_VAL;
         end else begin
            mem[i] <= mem_nxt[i];
         end
      end
   end

   // Write-error pulse, one cycle after the rejected write.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_w_err <= 1'b0;
      end else begin
         o_w_err <= w_reject;
      end
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_rd
      logic [AW-1:0]    rd_addr;
      logic [WIDTH-1:0] rd_data;
      logic             vld_out;
      logic [WIDTH-1:0] val_out;

      assign rd_addr                      = i_r_addr[p*AW +: AW];
      assign o_r_valid[p]                 = vld_out;
      assign o_r_value[p*WIDTH +: WIDTH]  = val_out;

      // Read mux; addresses beyond the array return zero.
      always_comb begin
         rd_data = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
               rd_data = mem[i];
            end
         end
      end

      if (RD_LAT == 1) begin : g_lat1
         // ---- stage p0: sample request, drive output directly ----
         // Output register: valid pulses per request, value holds between requests.
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_out <= 1'b0;
               val_out <= '0;
            end else begin
               vld_out <= i_r_en[p];
               if (i_r_en[p]) begin
                  val_out <= rd_data;
               end
            end
         end
      end else begin : g_lat2
         logic             vld_p0;
         logic [WIDTH-1:0] data_p0;

         // ---- stage p0: sample request and read data ----
         // Request valid, flushed by reset so in-flight reads are dropped.
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_p0 <= 1'b0;
            end else begin
               vld_p0 <= i_r_en[p];
            end
         end

         // Captured read data; only consumed when vld_p0 is set.
         always_ff @(posedge clk) begin
            data_p0 <= rd_data;
         end

         // ---- stage p1: output register ----
         // Output register: valid pulses per request, value holds between requests.
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_out <= 1'b0;
               val_out <= '0;
            end else begin
               vld_out <= vld_p0;
               if (vld_p0) begin
                  val_out <= data_p0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed stimulus driven into two register_bank instances
// (DEPTH=32/RD_LAT=2 and DEPTH=20/RD_LAT=1), both with reg 5 W1C and reg 7 RO,
// checked every cycle against a behavioural model plus literal expectations.
module tb_register_bank;

   logic        clk;
   logic        reset;
   logic        w_en;
   logic [4:0]  w_addr;
   logic [15:0] w_value;
   logic [1:0]  w_strb;
   logic        hw_en;
   logic [4:0]  hw_addr;
   logic [15:0] hw_value;
   logic [1:0]  r_en;
   logic [9:0]  r_addr;

   logic        err_a, err_b;
   logic [31:0] rv_a, rv_b;
   logic [1:0]  vld_a, vld_b;
   logic [15:0] mem_a [32];
   logic [15:0] mem_b [20];

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model state, index 0 = instance a, 1 = instance b
   int          dep [2] = '{32, 20};
   int          lat [2] = '{2, 1};
   logic [15:0] mm   [2][32];
   logic        pvld [2][2];
   logic [15:0] pval [2][2];
   logic        ovld [2][2];
   logic [15:0] oval [2][2];
   logic        oerr [2];

   register_bank #(
      .WIDTH(16), .DEPTH(32), .N_RD(2), .LANE_W(8), .RD_LAT(2),
      .RST_VAL(16'h0000), .RO_MASK(32'h0000_0080), .W1C_MASK(32'h0000_0020)
   ) dut_a (
      .clk(clk), .reset(reset),
      .i_w_en(w_en), .i_w_addr(w_addr), .i_w_value(w_value), .i_w_strb(w_strb),
      .o_w_err(err_a),
      .i_hw_en(hw_en), .i_hw_addr(hw_addr), .i_hw_value(hw_value),
      .i_r_en(r_en), .i_r_addr(r_addr), .o_r_value(rv_a), .o_r_valid(vld_a),
      .o_mem(mem_a)
   );

   register_bank #(
      .WIDTH(16), .DEPTH(20), .N_RD(2), .LANE_W(8), .RD_LAT(1),
      .RST_VAL(16'h0000), .RO_MASK(20'h00080), .W1C_MASK(20'h00020)
   ) dut_b (
      .clk(clk), .reset(reset),
      .i_w_en(w_en), .i_w_addr(w_addr), .i_w_value(w_value), .i_w_strb(w_strb),
      .o_w_err(err_b),
      .i_hw_en(hw_en), .i_hw_addr(hw_addr), .i_hw_value(hw_value),
      .i_r_en(r_en), .i_r_addr(r_addr), .o_r_value(rv_b), .o_r_valid(vld_b),
      .o_mem(mem_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: reads see the pre-edge image, then writes apply.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            for (int i = 0; i < 32; i++) mm[k][i] = 16'h0000;
            for (int p = 0; p < 2; p++) begin
               pvld[k][p] = 1'b0;
               ovld[k][p] = 1'b0;
               oval[k][p] = 16'h0000;
            end
            oerr[k] = 1'b0;
         end else begin
            logic [15:0] m;
            for (int p = 0; p < 2; p++) begin
               int          a;
               logic [15:0] d;
               a = int'(r_addr[p*5 +: 5]);
               d = (a < dep[k]) ? mm[k][a] : 16'h0000;
               if (lat[k] == 1) begin
                  ovld[k][p] = r_en[p];
                  if (r_en[p]) oval[k][p] = d;
               end else begin
                  ovld[k][p] = pvld[k][p];
                  if (pvld[k][p]) oval[k][p] = pval[k][p];
                  pvld[k][p] = r_en[p];
                  pval[k][p] = d;
               end
            end
            oerr[k] = w_en && (w_strb != 2'b00) &&
                      ((int'(w_addr) >= dep[k]) || (w_addr == 5'd7));
            m = {{8{w_strb[1]}}, {8{w_strb[0]}}};
            for (int a = 0; a < dep[k]; a++) begin
               logic bh, hh;
               bh = w_en && (int'(w_addr) == a);
               hh = hw_en && (int'(hw_addr) == a);
               if (a == 7) begin
                  if (hh) mm[k][a] = hw_value;
               end else if (a == 5) begin
                  if (bh) mm[k][a] = mm[k][a] & ~(w_value & m);
                  if (hh) mm[k][a] = mm[k][a] | hw_value;
               end else begin
                  if (hh) mm[k][a] = hw_value;
                  if (bh) mm[k][a] = (mm[k][a] & ~m) | (w_value & m);
               end
            end
         end
      end
   end

   task automatic cmp(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
      end
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp(nm, -1, act, exp);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("r_valid", 0, {30'd0, vld_a}, {30'd0, ovld[0][1], ovld[0][0]});
         cmp("r_value", 0, rv_a, {oval[0][1], oval[0][0]});
         cmp("w_err",   0, {31'd0, err_a}, {31'd0, oerr[0]});
         cmp("r_valid", 1, {30'd0, vld_b}, {30'd0, ovld[1][1], ovld[1][0]});
         cmp("r_value", 1, rv_b, {oval[1][1], oval[1][0]});
         cmp("w_err",   1, {31'd0, err_b}, {31'd0, oerr[1]});
         for (int i = 0; i < 32; i++) cmp("o_mem", 0, {16'd0, mem_a[i]}, {16'd0, mm[0][i]});
         for (int i = 0; i < 20; i++) cmp("o_mem", 1, {16'd0, mem_b[i]}, {16'd0, mm[1][i]});
      end
   end

   task automatic idle();
      w_en = 1'b0; w_addr = '0; w_value = '0; w_strb = '0;
      hw_en = 1'b0; hw_addr = '0; hw_value = '0;
      r_en = '0; r_addr = '0;
   endtask

   task automatic bus(input logic [4:0] a, input logic [15:0] v, input logic [1:0] s);
      w_en = 1'b1; w_addr = a; w_value = v; w_strb = s;
   endtask

   task automatic hw(input logic [4:0] a, input logic [15:0] v);
      hw_en = 1'b1; hw_addr = a; hw_value = v;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      lit("rst_err_a", {31'd0, err_a}, 32'd0);
      lit("rst_vld_b", {30'd0, vld_b}, 32'd0);
      lit("rst_mem_a31", {16'd0, mem_a[31]}, 32'd0);
      reset = 1'b0;

      // Read every register on both ports after reset
      for (int a = 0; a < 32; a++) begin
         r_en = 2'b11;
         r_addr = {5'(a), 5'(a)};
         @(negedge clk);
      end
      idle();
      repeat (3) @(negedge clk);

      // Byte strobe on RW reg 3, read back at latency 2
      bus(5'd3, 16'h1234, 2'b11); @(negedge clk);
      bus(5'd3, 16'hABCD, 2'b01); @(negedge clk);
      idle();
      lit("t2_model_reg3", {16'd0, mm[0][3]}, 32'h12CD);
      lit("t2_mem_reg3", {16'd0, mem_a[3]}, 32'h12CD);
      r_en = 2'b01; r_addr = {5'd0, 5'd3};
      @(negedge clk);
      idle();
      lit("t2_vld_early", {31'd0, vld_a[0]}, 32'd0);
      lit("t2_rd_lat1", {16'd0, rv_b[15:0]}, 32'h12CD);
      @(negedge clk);
      lit("t2_vld_lat2", {31'd0, vld_a[0]}, 32'd1);
      lit("t2_rd_lat2", {16'd0, rv_a[15:0]}, 32'h12CD);

      // W1C reg 5: hw set, bus clear, then set beats clear
      hw(5'd5, 16'h00F0); @(negedge clk);
      idle();
      bus(5'd5, 16'h0030, 2'b11); @(negedge clk);
      idle();
      lit("t3_model_reg5", {16'd0, mm[0][5]}, 32'h00C0);
      lit("t3_mem_reg5", {16'd0, mem_a[5]}, 32'h00C0);
      bus(5'd5, 16'h0010, 2'b11); hw(5'd5, 16'h0010); @(negedge clk);
      idle();
      lit("t3_set_beats_clr", {16'd0, mem_b[5]}, 32'h00D0);

      // RO reg 7: bus write rejected, hw update lands
      bus(5'd7, 16'hFFFF, 2'b11); @(negedge clk);
      idle();
      lit("t4_err_pulse", {31'd0, err_a}, 32'd1);
      lit("t4_reg7_kept", {16'd0, mem_a[7]}, 32'h0000);
      @(negedge clk);
      lit("t4_err_drop", {31'd0, err_a}, 32'd0);
      hw(5'd7, 16'h5A5A); @(negedge clk);
      idle();
      lit("t4_hw_reg7", {16'd0, mem_b[7]}, 32'h5A5A);
      lit("t4_hw_no_err", {31'd0, err_b}, 32'd0);

      // Address beyond DEPTH=20 on instance b (still legal on instance a)
      bus(5'd25, 16'h1234, 2'b11); @(negedge clk);
      idle();
      lit("t5_err_b", {31'd0, err_b}, 32'd1);
      lit("t5_err_a", {31'd0, err_a}, 32'd0);
      lit("t5_model_a25", {16'd0, mm[0][25]}, 32'h1234);
      @(negedge clk);
      lit("t5_err_b_drop", {31'd0, err_b}, 32'd0);
      r_en = 2'b10; r_addr = {5'd25, 5'd0}; @(negedge clk);
      idle();
      lit("t5_vld_oob", {31'd0, vld_b[1]}, 32'd1);
      lit("t5_rd_oob", {16'd0, rv_b[31:16]}, 32'h0000);
      @(negedge clk);
      lit("t5_rd_a25", {16'd0, rv_a[31:16]}, 32'h1234);

      // Back-to-back reads on both ports after a few hw updates
      for (int i = 0; i < 4; i++) begin
         hw(5'(10 + i), 16'(16'h1111 * (i + 1)));
         @(negedge clk);
      end
      idle();
      for (int i = 0; i < 6; i++) begin
         r_en = 2'b11; r_addr = {5'(13 - i), 5'(9 + i)};
         @(negedge clk);
      end
      idle();
      repeat (2) @(negedge clk);

      // Read-before-write on reg 2
      bus(5'd2, 16'hBEEF, 2'b11); @(negedge clk);
      bus(5'd2, 16'h0001, 2'b11); r_en = 2'b01; r_addr = {5'd0, 5'd2};
      @(negedge clk);
      idle();
      lit("t6_rbw_b", {16'd0, rv_b[15:0]}, 32'hBEEF);
      lit("t6_mem_reg2", {16'd0, mem_a[2]}, 32'h0001);
      @(negedge clk);
      lit("t6_rbw_a", {16'd0, rv_a[15:0]}, 32'hBEEF);

      // Reset right after a request drops it at latency 2
      r_en = 2'b01; r_addr = {5'd0, 5'd2}; @(negedge clk);
      idle();
      reset = 1'b1; @(negedge clk);
      lit("t6_flush_vld", {31'd0, vld_a[0]}, 32'd0);
      reset = 1'b0; @(negedge clk);
      lit("t6_flush_vld2", {31'd0, vld_a[0]}, 32'd0);
      lit("t6_rst_reg2", {16'd0, mem_a[2]}, 32'h0000);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
